// File: rtl/user_harness_pkg.sv
// Shared definitions for the Wishbone test harness around user_module:
// register offsets, STATUS field positions and the pulse-generator states.
package user_harness_pkg;

  localparam logic [7:0] REG_DRIVE  = 8'h00;
  localparam logic [7:0] REG_STEP   = 8'h04;
  localparam logic [7:0] REG_FIFO   = 8'h08;
  localparam logic [7:0] REG_STATUS = 8'h0C;

  localparam int STATUS_BUSY_BIT = 4;
  localparam int STATUS_OVF_BIT  = 8;
  localparam int FIFO_VALID_BIT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } pulse_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead FIFO: rd_data always presents the oldest entry.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wr_data,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [CW-1:0]    count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == CW'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem[rd_ptr_reg];
  assign count   = count_reg;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_reg] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

endmodule

// File: rtl/user_module_wb_harness.sv
// Wishbone slave that drives user_module inputs, generates clock bursts on
// mod_in[0] and captures mod_out after every pulse into a readable FIFO.
module user_module_wb_harness
  import user_harness_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
  parameter int          HALF_PERIOD = 2,
  parameter int          FIFO_DEPTH  = 8
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic [31:0] wbs_dat_o,
  output logic [7:0]  mod_in,
  input  logic [7:0]  mod_out
);

  localparam int PW = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic         ack_reg;
  logic [31:0]  dat_reg;
  logic [7:1]   drive_reg;
  logic         overflow_reg;
  pulse_state_e state_reg, state_next;
  logic [PW-1:0] phase_reg, phase_next;
  logic [15:0]  remaining_reg, remaining_next;

  logic         hit;
  logic         req;
  logic         wr_req;
  logic         rd_req;
  logic [7:0]   offset;
  logic [15:0]  wr_lanes;
  logic         step_start;
  logic         fifo_pop;
  logic         ovf_clear;
  logic         ovf_set;
  logic         sample_push;
  logic         phase_last;
  logic         busy;
  logic [31:0]  rd_word;
  logic [31:0]  status_word;

  logic [7:0]    fifo_rd_data;
  logic [CW-1:0] fifo_count;
  logic          fifo_full;
  logic          fifo_empty;

  logic unused_bits;
  assign unused_bits = ^{wbs_dat_i[31:16], wbs_sel_i[3:2]};

  assign hit    = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
  assign req    = wbs_cyc_i & wbs_stb_i & hit & ~ack_reg;
  assign wr_req = req & wbs_we_i;
  assign rd_req = req & ~wbs_we_i;
  assign offset = wbs_adr_i[7:0];

  // Unselected byte lanes contribute zero to the written value.
  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    assign wr_lanes[gi*8 +: 8] = wbs_sel_i[gi] ? wbs_dat_i[gi*8 +: 8] : 8'h00;
  end

  assign busy       = (state_reg != ST_IDLE);
  assign step_start = wr_req & (offset == REG_STEP) & ~busy & (wr_lanes != 16'h0000);
  assign fifo_pop   = rd_req & (offset == REG_FIFO);
  assign ovf_clear  = wr_req & (offset == REG_STATUS) & wr_lanes[STATUS_OVF_BIT];
  // full implies non-empty, so a same-cycle pop always makes room
  assign ovf_set    = sample_push & fifo_full & ~fifo_pop;
  assign phase_last = (phase_reg == PW'(HALF_PERIOD - 1));

  assign mod_in    = {drive_reg, (state_reg == ST_HIGH)};
  assign wbs_ack_o = ack_reg;
  assign wbs_dat_o = dat_reg;

  always_comb begin
    state_next     = state_reg;
    phase_next     = phase_reg;
    remaining_next = remaining_reg;
    sample_push    = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (step_start) begin
          state_next     = ST_HIGH;
          phase_next     = '0;
          remaining_next = wr_lanes;
        end
      end
      ST_HIGH: begin
        if (phase_last) begin
          state_next = ST_LOW;
          phase_next = '0;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      ST_LOW: begin
        if (phase_last) begin
          sample_push    = 1'b1;
          phase_next     = '0;
          remaining_next = remaining_reg - 16'd1;
          state_next     = (remaining_reg == 16'd1) ? ST_IDLE : ST_HIGH;
        end else begin
          phase_next = phase_reg + PW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    status_word                  = 32'(fifo_count);
    status_word[STATUS_BUSY_BIT] = busy;
    status_word[STATUS_OVF_BIT]  = overflow_reg;
  end

  always_comb begin
    rd_word = 32'h0;
    case (offset)
      REG_DRIVE:  rd_word = {24'h0, drive_reg, 1'b0};
      REG_STEP:   rd_word = {16'h0, remaining_reg};
      REG_FIFO: begin
        if (!fifo_empty) begin
          rd_word[7:0]           = fifo_rd_data;
          rd_word[FIFO_VALID_BIT] = 1'b1;
        end
      end
      REG_STATUS: rd_word = status_word;
      default:    rd_word = 32'h0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      ack_reg       <= 1'b0;
      dat_reg       <= 32'h0;
      drive_reg     <= '0;
      overflow_reg  <= 1'b0;
      state_reg     <= ST_IDLE;
      phase_reg     <= '0;
      remaining_reg <= 16'h0;
    end else begin
      ack_reg       <= req;
      dat_reg       <= rd_req ? rd_word : 32'h0;
      if (wr_req && (offset == REG_DRIVE) && wbs_sel_i[0]) begin
        drive_reg <= wbs_dat_i[7:1];
      end
      overflow_reg  <= (overflow_reg & ~ovf_clear) | ovf_set;
      state_reg     <= state_next;
      phase_reg     <= phase_next;
      remaining_reg <= remaining_next;
    end
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (wb_clk_i),
    .srst    (wb_rst_i),
    .push    (sample_push),
    .pop     (fifo_pop),
    .wr_data (mod_out),
    .rd_data (fifo_rd_data),
    .count   (fifo_count),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

endmodule

// File: tb/tb_user_module_wb_harness.sv
// Directed bench: user_module is stubbed as an 8-bit counter of mod_in[0] rising edges.
module tb_user_module_wb_harness;

  logic        wb_clk_i = 1'b0;
  logic        wb_rst_i = 1'b1;
  logic        wbs_cyc_i = 1'b0;
  logic        wbs_stb_i = 1'b0;
  logic        wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = 32'h0;
  logic [31:0] wbs_dat_i = 32'h0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [7:0]  mod_in;
  logic [7:0]  mod_out;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] BASE = 32'h3000_0000;

  always #5 wb_clk_i = ~wb_clk_i;

  user_module_wb_harness dut (
    .wb_clk_i  (wb_clk_i),
    .wb_rst_i  (wb_rst_i),
    .wbs_cyc_i (wbs_cyc_i),
    .wbs_stb_i (wbs_stb_i),
    .wbs_we_i  (wbs_we_i),
    .wbs_sel_i (wbs_sel_i),
    .wbs_adr_i (wbs_adr_i),
    .wbs_dat_i (wbs_dat_i),
    .wbs_ack_o (wbs_ack_o),
    .wbs_dat_o (wbs_dat_o),
    .mod_in    (mod_in),
    .mod_out   (mod_out)
  );

  logic [7:0] stub_cnt;
  logic       stub_prev;
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      stub_cnt  <= 8'h00;
      stub_prev <= 1'b0;
    end else begin
      stub_prev <= mod_in[0];
      if (mod_in[0] && !stub_prev) stub_cnt <= stub_cnt + 8'h01;
    end
  end
  assign mod_out = stub_cnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wb_xfer(input logic we, input logic [7:0] off, input logic [31:0] wdata,
                         output logic [31:0] rdata);
    bit acked = 0;
    wbs_adr_i = BASE | {24'h0, off};
    wbs_dat_i = wdata;
    wbs_we_i  = we;
    wbs_sel_i = 4'hF;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    rdata     = 32'h0;
    for (int i = 0; i < 8; i++) begin
      @(posedge wb_clk_i); #1;
      if (wbs_ack_o) begin
        acked = 1;
        rdata = wbs_dat_o;
        break;
      end
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    wbs_we_i  = 1'b0;
    check("ack_timeout", 32'(acked), 32'd1);
    $display("%s off=0x%02h wdata=0x%08h rdata=0x%08h", we ? "WR" : "RD", off, wdata, rdata);
  endtask

  task automatic wb_write(input logic [7:0] off, input logic [31:0] wdata);
    logic [31:0] dummy;
    wb_xfer(1'b1, off, wdata, dummy);
  endtask

  task automatic wb_read_check(input string tag, input logic [7:0] off, input logic [31:0] exp);
    logic [31:0] rdata;
    wb_xfer(1'b0, off, 32'h0, rdata);
    check(tag, rdata, exp);
  endtask

  initial begin
    logic [13:0] pat;
    logic        seen_ack;
    int          exp_cnt;

    repeat (3) @(posedge wb_clk_i);
    #1;
    check("rst_ack", 32'(wbs_ack_o), 32'h0);
    check("rst_dat", wbs_dat_o, 32'h0);
    check("rst_mod_in", 32'(mod_in), 32'h0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;

    wb_read_check("status_reset", 8'h0C, 32'h000);
    wb_read_check("fifo_reset", 8'h08, 32'h000);

    // DRIVE register
    wb_write(8'h00, 32'hA6);
    check("drive_mod_in", 32'(mod_in), 32'hA6);
    wb_read_check("drive_rb", 8'h00, 32'hA6);
    wb_write(8'h00, 32'hFF);
    check("drive_bit0_mod_in", 32'(mod_in), 32'hFE);
    wb_read_check("drive_bit0_rb", 8'h00, 32'hFE);
    wb_read_check("unmapped", 8'h10, 32'h0);

    // Non-hit address must never be acknowledged
    seen_ack  = 1'b0;
    wbs_adr_i = BASE + 32'h100;
    wbs_we_i  = 1'b0;
    wbs_cyc_i = 1'b1;
    wbs_stb_i = 1'b1;
    repeat (4) begin
      @(posedge wb_clk_i); #1;
      seen_ack = seen_ack | wbs_ack_o;
    end
    wbs_cyc_i = 1'b0;
    wbs_stb_i = 1'b0;
    check("nonhit_ack", 32'(seen_ack), 32'h0);
    $display("RD nonhit adr=0x%08h acked=%0d", BASE + 32'h100, seen_ack);

    // STEP=3: waveform and captured samples
    wb_write(8'h04, 32'd3);
    for (int i = 0; i < 14; i++) begin
      pat[i] = mod_in[0];
      @(posedge wb_clk_i); #1;
    end
    check("step3_wave", 32'(pat), 32'h0333);
    wb_read_check("step3_status", 8'h0C, 32'h003);
    wb_read_check("step3_fifo0", 8'h08, 32'h101);
    wb_read_check("step3_fifo1", 8'h08, 32'h102);
    wb_read_check("step3_fifo2", 8'h08, 32'h103);
    wb_read_check("step3_fifo_empty", 8'h08, 32'h000);
    exp_cnt = 3;

    // STEP=10 into an 8-deep FIFO: overflow, first 8 kept
    wb_write(8'h04, 32'd10);
    wb_read_check("step10_remaining", 8'h04, 32'd10);
    wb_read_check("step10_busy", 8'h0C, 32'h010);
    repeat (45) @(posedge wb_clk_i);
    #1;
    wb_read_check("step10_status", 8'h0C, 32'h108);
    for (int i = 0; i < 8; i++) begin
      wb_read_check($sformatf("step10_fifo%0d", i), 8'h08, 32'h100 | 32'(exp_cnt + 1 + i));
    end
    exp_cnt = exp_cnt + 10;
    wb_read_check("step10_drained", 8'h0C, 32'h100);
    wb_write(8'h0C, 32'h100);
    wb_read_check("ovf_cleared", 8'h0C, 32'h000);

    // STEP while busy is ignored
    wb_write(8'h04, 32'd5);
    wb_write(8'h04, 32'd7);
    repeat (30) @(posedge wb_clk_i);
    #1;
    wb_read_check("step5_status", 8'h0C, 32'h005);
    for (int i = 0; i < 5; i++) begin
      wb_read_check($sformatf("step5_fifo%0d", i), 8'h08, 32'h100 | 32'(exp_cnt + 1 + i));
    end
    wb_read_check("step5_fifo_empty", 8'h08, 32'h000);

    // STEP=0 never starts a burst
    wb_write(8'h04, 32'd0);
    check("step0_clk", 32'(mod_in[0]), 32'h0);
    wb_read_check("step0_status", 8'h0C, 32'h000);

    // Reset in the middle of a HIGH phase
    wb_write(8'h04, 32'd4);
    check("midhigh_clk", 32'(mod_in[0]), 32'h1);
    wb_rst_i = 1'b1;
    @(posedge wb_clk_i); #1;
    check("rst_mid_mod_in", 32'(mod_in), 32'h0);
    wb_rst_i = 1'b0;
    @(posedge wb_clk_i); #1;
    wb_read_check("rst_mid_status", 8'h0C, 32'h000);
    wb_read_check("rst_mid_remaining", 8'h04, 32'h0);
    wb_read_check("rst_mid_fifo", 8'h08, 32'h000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
